// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized data memory: access-size encoding,
// controller states, and the byte-enable / alignment rules for RISC-V B/H/W.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_ILL = 2'd3
  } mem_size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

  // Byte lanes touched by an access of the given size at byte offset a.
  function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] a);
    logic [3:0] en;
    case (size)
      SZ_B:    en = 4'b0001 << a;
      SZ_H:    en = 4'b0011 << a;
      SZ_W:    en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Halves must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] a);
    logic mis;
    case (size)
      SZ_H:    mis = a[0];
      SZ_W:    mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory: store-side byte enables and
// data replication across lanes, load-side lane extraction with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  mem_size_e   size,
  input  logic [1:0]  addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Store path: right-aligned data copied into every lane so the enables pick the right one.
  always_comb begin
    be = byte_en(size, addr_lo);
    case (size)
      SZ_B:    wdata_lane = {4{wdata[7:0]}};
      SZ_H:    wdata_lane = {2{wdata[15:0]}};
      default: wdata_lane = wdata;
    endcase
  end

  // Load path: pick the addressed lane, then extend to 32 bits.
  always_comb begin
    case (addr_lo)
      2'd0:    rd_byte = rword[7:0];
      2'd1:    rd_byte = rword[15:8];
      2'd2:    rd_byte = rword[23:16];
      default: rd_byte = rword[31:24];
    endcase
    rd_half = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_B:    rdata_ext = ld_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_H:    rdata_ext = ld_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      SZ_W:    rdata_ext = rword;
      default: rdata_ext = 32'b0;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed 32-bit data memory with B/H/W sized accesses behind a
// valid/ready request port and a one-cycle registered response.
// After reset the array is zeroed by hardware one word per cycle before
// requests are accepted.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_CLEAR | writing zero to word[clr_idx] each cycle, req_ready low
//   ST_READY | array usable, req_ready held high until the next reset
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned   AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0]   SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  dmem_state_e   state;
  logic [AW-1:0] clr_idx;

  mem_size_e     size;
  logic [31:0]   offset;
  logic          in_range;
  logic          req_err;
  logic          accept;
  logic [AW-1:0] word_idx;

  logic [3:0]    be;
  logic [31:0]   wdata_lane;
  logic [31:0]   rdata_ext;

  logic [31:0]   mem [DEPTH_WORDS];

  // Range check is done on the unwrapped offset so addresses below the base never alias in.
  assign size     = mem_size_e'(req_size);
  assign offset   = req_addr - BASE_ADDR;
  assign in_range = (req_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign req_err  = !in_range || (size == SZ_ILL) || is_misaligned(size, req_addr[1:0]);
  assign word_idx = offset[AW+1:2];
  assign accept   = req_valid && req_ready;

  dmem_lane_align u_lane_align (
    .size        (size),
    .addr_lo     (req_addr[1:0]),
    .ld_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .rword       (mem[word_idx]),
    .be          (be),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext)
  );

  // Clear sequencer: walk the array once after reset, then open the request port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_idx   <= '0;
      req_ready <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state     <= ST_READY;
            req_ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + AW'(1);
          end
        end
        ST_READY: req_ready <= 1'b1;
      endcase
    end
  end

  // Storage array: clear writes while sequencing, otherwise byte-enabled stores; errors never write.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  // Response registers: one strobe per accepted request, data only for good loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && req_err;
      rsp_rdata <= (accept && !req_we && !req_err) ? rdata_ext : 32'b0;
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed plus randomized checks of data_memory_sized against a byte-array
// reference model of the RISC-V sized-access rules.
module tb_data_memory_sized;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;

  logic [7:0]  ref_mem [0:4095];

  logic        e_err;
  logic [31:0] e_rd;
  logic [31:0] rd_obs;
  int          n_clr;
  logic        seen_rsp;
  logic        v;
  int          nz_cnt;
  int          val_cnt;

  always #5 clk = ~clk;

  data_memory_sized #(
    .DEPTH_WORDS    (1024),
    .BASE_ADDR      (32'h0),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as 4096 bytes, accesses as 1/2/4 consecutive little-endian bytes.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd);
    int nb;
    int a;
    nb  = 1 << sz;
    rd  = 32'h0;
    err = (sz == 2'd3) || ((addr & 32'(nb - 1)) != 0) || (addr >= 32'd4096);
    if (err) return;
    a = int'(addr);
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) rd = rd | (32'(ref_mem[a + i]) << (8 * i));
      if (!uns && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
    end
  endtask

  // Single isolated request: response must appear the cycle after, then go idle.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
    logic        m_err;
    logic [31:0] m_rd;
    model(we, sz, uns, addr, wd, m_err, m_rd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_err"},   32'(rsp_err),   32'(m_err));
    check({tag, "_rdata"}, rsp_rdata,      m_rd);
    rd = rsp_rdata;
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(rsp_valid), 32'd0);
  endtask

  // Count cycles from reset release until req_ready rises, bounded.
  task automatic wait_ready(output int n, output logic seen);
    n = 0;
    seen = 1'b0;
    while (n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) seen = 1'b1;
      if (req_ready) break;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

    // Reset values
    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata,      32'd0);
    check("rst_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clear takes one cycle per word
    wait_ready(n_clr, seen_rsp);
    check("clear_cycles", 32'(n_clr), 32'd1024);
    check("clear_no_rsp", 32'(seen_rsp), 32'd0);
    do_req("lw_3fc", 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, rd_obs);
    check("lw_3fc_lit", rd_obs, 32'h0);

    // Sized loads from a stored word
    do_req("sw_0c",  1'b1, 2'd2, 1'b0, 32'h0C, 32'hDEADBEEF, rd_obs);
    do_req("lb_0c",  1'b0, 2'd0, 1'b0, 32'h0C, 32'h0, rd_obs);
    check("lb_0c_lit", rd_obs, 32'hFFFFFFEF);
    do_req("lbu_0f", 1'b0, 2'd0, 1'b1, 32'h0F, 32'h0, rd_obs);
    check("lbu_0f_lit", rd_obs, 32'h000000DE);
    do_req("lh_0e",  1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, rd_obs);
    check("lh_0e_lit", rd_obs, 32'hFFFFDEAD);
    do_req("lhu_0c", 1'b0, 2'd1, 1'b1, 32'h0C, 32'h0, rd_obs);
    check("lhu_0c_lit", rd_obs, 32'h0000BEEF);

    // Partial stores
    do_req("sb_0d", 1'b1, 2'd0, 1'b0, 32'h0D, 32'hFFFFFF55, rd_obs);
    do_req("lw_0c_a", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, rd_obs);
    check("lw_0c_a_lit", rd_obs, 32'hDEAD55EF);
    do_req("sh_0e", 1'b1, 2'd1, 1'b0, 32'h0E, 32'hABCD1234, rd_obs);
    do_req("lw_0c_b", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, rd_obs);
    check("lw_0c_b_lit", rd_obs, 32'h123455EF);

    // Error requests leave memory alone
    do_req("err_lw_02",   1'b0, 2'd2, 1'b0, 32'h02,   32'h0, rd_obs);
    do_req("err_lh_01",   1'b0, 2'd1, 1'b0, 32'h01,   32'h0, rd_obs);
    do_req("err_ill",     1'b0, 2'd3, 1'b0, 32'h0C,   32'h0, rd_obs);
    do_req("err_lw_1000", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, rd_obs);
    do_req("err_sw_1000", 1'b1, 2'd2, 1'b0, 32'h1000, 32'h11111111, rd_obs);
    do_req("err_sh_0d",   1'b1, 2'd1, 1'b0, 32'h0D,   32'h7777, rd_obs);
    do_req("err_sw_0e",   1'b1, 2'd2, 1'b0, 32'h0E,   32'h99999999, rd_obs);
    do_req("err_ill_st",  1'b1, 2'd3, 1'b0, 32'h0C,   32'h88888888, rd_obs);
    do_req("lw_0c_c", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, rd_obs);
    check("lw_0c_c_lit", rd_obs, 32'h123455EF);
    do_req("sw_ffc", 1'b1, 2'd2, 1'b0, 32'hFFC, 32'h0BADF00D, rd_obs);
    do_req("lw_ffc", 1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, rd_obs);
    check("lw_ffc_lit", rd_obs, 32'h0BADF00D);

    // Back-to-back store then load of the same word
    model(1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5A5A5, e_err, e_rd);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check("b2b_sw_valid", 32'(rsp_valid), 32'd1);
    check("b2b_sw_err",   32'(rsp_err),   32'd0);
    req_we = 1'b0;
    model(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, e_err, e_rd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_lw_valid", 32'(rsp_valid), 32'd1);
    check("b2b_lw_rdata", rsp_rdata, e_rd);
    check("b2b_lw_lit",   rsp_rdata, 32'hA5A5A5A5);
    @(posedge clk); #1;
    check("b2b_idle", 32'(rsp_valid), 32'd0);

    // Randomized traffic with gaps and back-to-back runs
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] sz;
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)      req_addr = 32'($urandom_range(0, 255));
      else if (r < 9) req_addr = 32'($urandom_range(0, 8191));
      else            req_addr = $urandom;
      r = $urandom_range(0, 7);
      sz = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      req_size = sz;
      req_we = 1'($urandom_range(0, 1));
      req_unsigned = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      req_valid = v;
      if (v) model(req_we, sz, req_unsigned, req_addr, req_wdata, e_err, e_rd);
      @(posedge clk); #1;
      check("rnd_valid", 32'(rsp_valid), 32'(v));
      if (v) begin
        check("rnd_err",   32'(rsp_err), 32'(e_err));
        check("rnd_rdata", rsp_rdata,    e_rd);
      end
    end
    req_valid = 1'b0;

    // Reset in the middle of a clear restarts the sweep
    do_req("sw_3fc", 1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D, rd_obs);
    do_req("sw_000", 1'b1, 2'd2, 1'b0, 32'h000, 32'h12345678, rd_obs);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rst2_ready", 32'(req_ready), 32'd0);
    check("rst2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    check("mid_clear_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    // A store presented during the clear must not be taken
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
    wait_ready(n_clr, seen_rsp);
    check("reclear_cycles", 32'(n_clr), 32'd1024);
    check("reclear_no_rsp", 32'(seen_rsp), 32'd0);

    nz_cnt = 0;
    val_cnt = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      req_addr = 32'(i * 4);
      @(posedge clk); #1;
      if (rsp_valid) val_cnt++;
      if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) nz_cnt++;
    end
    req_valid = 1'b0;
    check("sweep_valid_cnt", 32'(val_cnt), 32'd1024);
    check("sweep_nonzero",   32'(nz_cnt),  32'd0);
    do_req("post_lw_3fc", 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, rd_obs);
    do_req("post_lw_040", 1'b0, 2'd2, 1'b0, 32'h040, 32'h0, rd_obs);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
